// File: rtl/block_result_accum_if.sv
// Tile handshake bundle between the block multiply stage, the accumulator and its consumer.
// sat_flag exists only when BLOCK_ACC_SAT_EN is defined.
interface block_result_accum_if #(
    parameter int BIT_WIDTH = 16,
    parameter int KBLK_W    = 4
);
    logic                   start;
    logic [KBLK_W-1:0]      num_kblk;
    logic                   ready_start;
    logic [4*BIT_WIDTH-1:0] in_row0;
    logic [4*BIT_WIDTH-1:0] in_row1;
    logic [4*BIT_WIDTH-1:0] in_row2;
    logic [4*BIT_WIDTH-1:0] in_row3;
    logic                   in_done;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*BIT_WIDTH-1:0] out_row0;
    logic [4*BIT_WIDTH-1:0] out_row1;
    logic [4*BIT_WIDTH-1:0] out_row2;
    logic [4*BIT_WIDTH-1:0] out_row3;
    logic                   busy;
    logic                   drop_err;
`ifdef BLOCK_ACC_SAT_EN
    logic                   sat_flag;
`endif

    modport slave (
        input  start, num_kblk, in_row0, in_row1, in_row2, in_row3, in_done, out_ready,
        output ready_start, out_valid, out_row0, out_row1, out_row2, out_row3, busy, drop_err
`ifdef BLOCK_ACC_SAT_EN
        , output sat_flag
`endif
    );

    modport master (
        output start, num_kblk, in_row0, in_row1, in_row2, in_row3, in_done, out_ready,
        input  ready_start, out_valid, out_row0, out_row1, out_row2, out_row3, busy, drop_err
`ifdef BLOCK_ACC_SAT_EN
        , input sat_flag
`endif
    );
endinterface

// File: rtl/block_result_accum.sv
// Purpose: per-lane accumulation of 4x4 block-multiply results over N K-blocks (BLOCK_ACC_SAT_EN: saturating adds + sat_flag).
// Latency: out_valid rises 1 cycle after the final in_done; tile then held until out_ready.
// Backpressure: tile held in HOLD while out_ready=0; in_done outside ACCUM is dropped and flagged in drop_err.
module block_result_accum #(
    parameter int BIT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int KBLK_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    block_result_accum_if.slave  bus
);
    localparam int RW = 4 * BIT_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    // Inputs and outputs share one Q format, so FRAC_WIDTH only has to be representable.
    if (FRAC_WIDTH >= BIT_WIDTH) begin : g_bad_q_format
        $error("FRAC_WIDTH must be smaller than BIT_WIDTH");
    end

    logic [1:0]        state;
    logic [KBLK_W-1:0] n_lat;
    logic [KBLK_W-1:0] cnt;
    logic [RW-1:0]     acc     [4];
    logic [RW-1:0]     out_row [4];
    logic [RW-1:0]     in_row  [4];
    logic [RW-1:0]     sum_row [4];
    logic              drop_err;
    logic              handshake;
    logic              ready_start;
    logic              accept_start;
    logic              last_blk;
    logic [KBLK_W-1:0] n_next;
    logic              sat_any;
`ifdef BLOCK_ACC_SAT_EN
    logic              sat_flag;
`endif

    assign in_row[0] = bus.in_row0;
    assign in_row[1] = bus.in_row1;
    assign in_row[2] = bus.in_row2;
    assign in_row[3] = bus.in_row3;

    assign handshake    = (state == S_HOLD) && bus.out_ready;
    assign ready_start  = (state == S_IDLE) || handshake;
    assign accept_start = bus.start && ready_start;
    assign last_blk     = (({1'b0, cnt} + (KBLK_W+1)'(1)) == {1'b0, n_lat});
    assign n_next       = (bus.num_kblk == '0) ? KBLK_W'(1) : bus.num_kblk;

    // Independent per-lane adders; no carry crosses a lane boundary.
    always_comb begin
        logic [BIT_WIDTH-1:0] a;
        logic [BIT_WIDTH-1:0] b;
        logic [BIT_WIDTH:0]   w;
        a       = '0;
        b       = '0;
        w       = '0;
        sat_any = 1'b0;
        for (int r = 0; r < 4; r++) begin
            sum_row[r] = '0;
            for (int l = 0; l < 4; l++) begin
                a = acc[r][l*BIT_WIDTH +: BIT_WIDTH];
                b = in_row[r][l*BIT_WIDTH +: BIT_WIDTH];
`ifdef BLOCK_ACC_SAT_EN
                w = {a[BIT_WIDTH-1], a} + {b[BIT_WIDTH-1], b};
                if (w[BIT_WIDTH] != w[BIT_WIDTH-1]) begin
                    sat_any = 1'b1;
                    sum_row[r][l*BIT_WIDTH +: BIT_WIDTH] = w[BIT_WIDTH] ? {1'b1, {(BIT_WIDTH-1){1'b0}}}
                                                                         : {1'b0, {(BIT_WIDTH-1){1'b1}}};
                end else begin
                    sum_row[r][l*BIT_WIDTH +: BIT_WIDTH] = w[BIT_WIDTH-1:0];
                end
`else
                w = {1'b0, a + b};
                sum_row[r][l*BIT_WIDTH +: BIT_WIDTH] = w[BIT_WIDTH-1:0];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            n_lat    <= '0;
            cnt      <= '0;
            drop_err <= 1'b0;
`ifdef BLOCK_ACC_SAT_EN
            sat_flag <= 1'b0;
`endif
            for (int r = 0; r < 4; r++) begin
                acc[r]     <= '0;
                out_row[r] <= '0;
            end
        end else begin
            if (bus.in_done && (state != S_ACCUM)) begin
                drop_err <= 1'b1;
            end
            if (accept_start) begin
                n_lat <= n_next;
                cnt   <= '0;
                state <= S_ACCUM;
`ifdef BLOCK_ACC_SAT_EN
                sat_flag <= 1'b0;
`endif
                for (int r = 0; r < 4; r++) begin
                    acc[r] <= '0;
                end
            end else begin
                case (state)
                    S_ACCUM: begin
                        if (bus.in_done) begin
                            cnt <= cnt + KBLK_W'(1);
`ifdef BLOCK_ACC_SAT_EN
                            sat_flag <= sat_flag | sat_any;
`endif
                            for (int r = 0; r < 4; r++) begin
                                acc[r] <= sum_row[r];
                            end
                            if (last_blk) begin
                                state <= S_HOLD;
                                for (int r = 0; r < 4; r++) begin
                                    out_row[r] <= sum_row[r];
                                end
                            end
                        end
                    end
                    S_HOLD: begin
                        if (handshake) begin
                            state <= S_IDLE;
                        end
                    end
                    S_IDLE: begin
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.ready_start = ready_start;
    assign bus.out_valid   = (state == S_HOLD);
    assign bus.busy        = (state != S_IDLE);
    assign bus.drop_err    = drop_err;
    assign bus.out_row0    = out_row[0];
    assign bus.out_row1    = out_row[1];
    assign bus.out_row2    = out_row[2];
    assign bus.out_row3    = out_row[3];
`ifdef BLOCK_ACC_SAT_EN
    assign bus.sat_flag    = sat_flag;
`endif
endmodule

// File: tb/tb_block_result_accum.sv
// Directed bench for block_result_accum: single/multi-block tiles, lane wrap (or saturation), back-to-back, drops, async reset.
module tb_block_result_accum;
    localparam int BW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    int   hs0    = 0;

    always #5 clk = ~clk;

    block_result_accum_if #(.BIT_WIDTH(BW), .KBLK_W(4)) bus ();

    block_result_accum #(.BIT_WIDTH(BW), .FRAC_WIDTH(8), .KBLK_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) hs_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [63:0] r0, input logic [63:0] r1,
                         input logic [63:0] r2, input logic [63:0] r3);
        bus.in_row0 = r0;
        bus.in_row1 = r1;
        bus.in_row2 = r2;
        bus.in_row3 = r3;
        bus.in_done = 1'b1;
        tick();
        bus.in_done = 1'b0;
        bus.in_row0 = '0;
        bus.in_row1 = '0;
        bus.in_row2 = '0;
        bus.in_row3 = '0;
    endtask

    task automatic begin_tile(input logic [3:0] n);
        bus.start    = 1'b1;
        bus.num_kblk = n;
        tick();
        bus.start    = 1'b0;
        bus.num_kblk = '0;
    endtask

    task automatic accept_tile();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.num_kblk  = '0;
        bus.in_row0   = '0;
        bus.in_row1   = '0;
        bus.in_row2   = '0;
        bus.in_row3   = '0;
        bus.in_done   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_drop", bus.drop_err, 0);
        check("rst_row0", bus.out_row0, 0);
        check("rst_ready_start", bus.ready_start, 1);
        rst_n = 1'b1;
        tick();

        // Single block
        begin_tile(4'd1);
        check("t1_busy", bus.busy, 1);
        check("t1_ready_start_accum", bus.ready_start, 0);
        pulse(64'h0100_0200_0300_0400, 64'h0, 64'h0, 64'h0);
        check("t1_valid", bus.out_valid, 1);
        check("t1_row0", bus.out_row0, 64'h0100_0200_0300_0400);
        check("t1_row1", bus.out_row1, 64'h0);
`ifdef BLOCK_ACC_SAT_EN
        check("t1_sat", bus.sat_flag, 0);
`endif
        bus.out_ready = 1'b1;
        #1;
        check("t1_ready_start_hs", bus.ready_start, 1);
        tick();
        bus.out_ready = 1'b0;
        check("t1_idle_valid", bus.out_valid, 0);
        check("t1_idle_busy", bus.busy, 0);
        check("t1_row0_retained", bus.out_row0, 64'h0100_0200_0300_0400);

        // Three blocks with idle gaps; a start in ACCUM must be ignored
        begin_tile(4'd3);
        for (int k = 0; k < 3; k++) begin
            pulse(64'h0080_0080_0080_0080, 64'h0080_0080_0080_0080,
                  64'h0080_0080_0080_0080, 64'h0080_0080_0080_0080);
            if (k < 2) begin
                check("t2_valid_early", bus.out_valid, 0);
                if (k == 0) begin_tile(4'd1);
                repeat (19) tick();
                check("t2_valid_gap", bus.out_valid, 0);
            end
        end
        check("t2_valid", bus.out_valid, 1);
        check("t2_row0", bus.out_row0, 64'h0180_0180_0180_0180);
        check("t2_row3", bus.out_row3, 64'h0180_0180_0180_0180);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_hold_valid", bus.out_valid, 1);
            check("t2_hold_row2", bus.out_row2, 64'h0180_0180_0180_0180);
        end
        accept_tile();

        // Lane isolation, wrap vs saturate
        begin_tile(4'd2);
        pulse(64'h0000_0000_7FFF_FFFF, 64'h0, 64'h0, 64'h8000_0001_1234_0000);
        pulse(64'h0000_0000_0001_0001, 64'h0, 64'h0, 64'hFFFF_0002_0001_0000);
        check("t3_valid", bus.out_valid, 1);
`ifdef BLOCK_ACC_SAT_EN
        check("t3_row0_sat", bus.out_row0, 64'h0000_0000_7FFF_0000);
        check("t3_row3_sat", bus.out_row3, 64'h8000_0003_1235_0000);
        check("t3_sat_flag", bus.sat_flag, 1);
`else
        check("t3_row0_wrap", bus.out_row0, 64'h0000_0000_8000_0000);
        check("t3_row3_wrap", bus.out_row3, 64'h7FFF_0003_1235_0000);
`endif
        accept_tile();

        // Back-to-back: tile B started in tile A's handshake cycle
        begin_tile(4'd1);
        pulse(64'h1111_1111_1111_1111, 64'h0010_0020_0030_0040, 64'h0, 64'h0);
        check("t4_a_valid", bus.out_valid, 1);
        check("t4_a_row1", bus.out_row1, 64'h0010_0020_0030_0040);
        hs0 = hs_cnt;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.num_kblk  = 4'd2;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        bus.num_kblk  = '0;
        check("t4_b_valid_low", bus.out_valid, 0);
        check("t4_b_busy", bus.busy, 1);
        pulse(64'h0, 64'h0001_0001_0001_0001, 64'h0, 64'h0);
        check("t4_b_valid_mid", bus.out_valid, 0);
        pulse(64'h0, 64'h0001_0001_0001_0001, 64'h0, 64'h0);
        check("t4_b_valid", bus.out_valid, 1);
        check("t4_b_row0", bus.out_row0, 64'h0);
        check("t4_b_row1", bus.out_row1, 64'h0002_0002_0002_0002);
        check("t4_a_accepted_once", hs_cnt - hs0, 1);
`ifdef BLOCK_ACC_SAT_EN
        check("t4_sat_cleared", bus.sat_flag, 0);
`endif
        accept_tile();

        // in_done while IDLE
        check("t5_drop_before", bus.drop_err, 0);
        pulse(64'hDEAD_BEEF_DEAD_BEEF, 64'h1, 64'h1, 64'h1);
        check("t5_drop_set", bus.drop_err, 1);
        check("t5_busy", bus.busy, 0);
        check("t5_valid", bus.out_valid, 0);
        check("t5_row1_kept", bus.out_row1, 64'h0002_0002_0002_0002);

        // num_kblk=0 behaves as 1
        begin_tile(4'd0);
        check("t6_busy", bus.busy, 1);
        pulse(64'h0, 64'h0, 64'h0005_0006_0007_0008, 64'h0);
        check("t6_valid", bus.out_valid, 1);
        check("t6_row2", bus.out_row2, 64'h0005_0006_0007_0008);
        accept_tile();

        // Async reset mid-ACCUM
        begin_tile(4'd2);
        pulse(64'h0001_0001_0001_0001, 64'h0, 64'h0, 64'h0);
        check("t7_valid_mid", bus.out_valid, 0);
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", bus.out_valid, 0);
        check("t7_rst_busy", bus.busy, 0);
        check("t7_rst_row2", bus.out_row2, 64'h0);
        check("t7_rst_rows", bus.out_row0 | bus.out_row1 | bus.out_row3, 64'h0);
        check("t7_rst_drop", bus.drop_err, 0);
        #2;
        rst_n = 1'b1;
        tick();
        begin_tile(4'd1);
        pulse(64'h0001_0002_0003_0004, 64'h0, 64'h0, 64'h0);
        check("t7_next_valid", bus.out_valid, 1);
        check("t7_next_row0", bus.out_row0, 64'h0001_0002_0003_0004);
        accept_tile();
        check("t7_idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
